prof_uart_tx: RTL and testbench
===============================

# prof_uart_tx

Readout end of the profiler: captures the 32-bit profile count on request and transmits it to the host as a fixed UART frame sequence (8N1). Sits between the profiler's `P_Count` output and the board's UART TX pin. It gives the host-side reader a path to collect profile results without a bus interface.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.

Ports:
- `clk` input, 1: single system clock; all logic on its rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `P_Count` input, 32: live profile count from the profiler.
- `P_Dump_Req` input, 1: level-sampled request to snapshot and send the count.
- `P_Tx` output, 1: UART serial out; idle high.
- `P_Busy` output, 1: high while a dump is in progress.
- `P_Done` output, 1: one-cycle pulse when the final stop bit completes.

## Operation

- **Reset values:** `P_Tx`=1, `P_Busy`=0, `P_Done`=0; FSM in IDLE; snapshot, byte index and bit counters are cleared.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE.** `P_Tx`=1. If `P_Dump_Req`=1 at a rising edge while `P_Busy`=0:
  - latch `P_Count` into the snapshot register;
  - set byte index to 0;
  - go to START and set `P_Busy`=1.
- **START.** `P_Tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- **DATA.** `P_Tx` = current byte bit[bit index], LSB first. Each bit is held for `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
- **STOP.** `P_Tx`=1 for `CLKS_PER_BIT` cycles. Then:
  - if more bytes remain: increment byte index and go to START;
  - otherwise: go to IDLE, set `P_Busy`=0 and pulse `P_Done`.
- **Byte order:** MSB byte first. Byte 0 = snapshot[31:24], byte 3 = snapshot[7:0].
- **Snapshot isolation:** changes on `P_Count` after capture do not affect the frames in flight.
- **Request while busy:** ignored, not queued. `P_Dump_Req` held high re-triggers only once `P_Busy` is low.
- **Reset mid-dump:** the frame is abandoned at the next edge. Outputs take their reset values; no `P_Done` pulse.
- **Bit timer:** down-counter of width clog2(`CLKS_PER_BIT`), reloaded at every bit boundary; there is no cumulative drift.

## Timing

- **Request to start bit:** a request sampled at edge k drives `P_Tx`=0 and `P_Busy`=1 from edge k. This is zero added latency.
- **Frame length:** each frame is 10 bits = 10×`CLKS_PER_BIT` cycles. Frames follow each other with no idle gap.
- **Dump length:** 4 frames, so `P_Busy` is high for exactly 40×`CLKS_PER_BIT` cycles, falling at edge k+40×`CLKS_PER_BIT`.
- **Done pulse:** `P_Done` is high for exactly the one cycle following that edge.
- **Back-to-back dumps:** minimum request-to-request spacing is 40×`CLKS_PER_BIT`+1 cycles. The IDLE cycle in which `P_Busy`=0 is the earliest accept point.
- **Output registering:** all outputs are registered. `P_Tx` has no combinational path from inputs.

## Configuration

- **`PROF_TX_CHECKSUM_EN` defined:**
  - a 5th frame is appended, carrying the XOR of the four snapshot bytes;
  - `P_Busy` spans 50×`CLKS_PER_BIT` cycles;
  - `P_Done` follows the 5th stop bit.
- **`PROF_TX_CHECKSUM_EN` undefined:** exactly 4 frames; no checksum logic is present.

## Test plan

- **Reset idle:** after `reset`, hold idle 100 cycles → `P_Tx`=1, `P_Busy`=0, `P_Done`=0 throughout.
- **Basic dump:** `CLKS_PER_BIT`=4, `P_Count`=0x12345678, pulse `P_Dump_Req` → decoded bytes 0x12, 0x34, 0x56, 0x78 with valid start/stop bits. `P_Busy` is high 160 cycles, then a single-cycle `P_Done`.
- **Checksum build:** with `PROF_TX_CHECKSUM_EN`, same stimulus → 5th byte 0x08 and `P_Busy` high 200 cycles.
- **Snapshot isolation:** change `P_Count` to 0xFFFFFFFF one cycle after the accepted request → transmitted bytes still 0x12, 0x34, 0x56, 0x78.
- **Request while busy, held request:**
  - pulse `P_Dump_Req` mid-dump → it is ignored, exactly one dump occurs;
  - hold `P_Dump_Req` high continuously → the second start bit begins exactly 1 cycle after `P_Busy` falls.
- **Reset mid-dump:** assert `reset` during byte 1 DATA → next edge gives `P_Tx`=1 and `P_Busy`=0, with no `P_Done`. A following request transmits a complete fresh dump.

Source files
------------

// File: rtl/prof_uart_tx.sv
// prof_uart_tx: snapshots the 32-bit profile count on request and sends it MSB byte first as 8N1 UART frames.
// Latency: start bit is driven from the same edge that accepts the request; a dump lasts 40*CLKS_PER_BIT cycles (50 with checksum).
// Backpressure: none; requests while busy are dropped, and a held request re-arms once P_Busy is low.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high
//   P_Count    - live profile count, captured when a dump starts
//   P_Dump_Req - level-sampled dump request
//   P_Tx       - UART serial output, idle high
//   P_Busy     - high while a dump is in progress
//   P_Done     - one-cycle pulse after the final stop bit
//
// Build option: define PROF_TX_CHECKSUM_EN to append a fifth frame holding the XOR of the four count bytes.

module prof_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] P_Count,
  input  logic        P_Dump_Req,
  output logic        P_Tx,
  output logic        P_Busy,
  output logic        P_Done
);

  // A clog2(CLKS_PER_BIT)-bit counter always holds CLKS_PER_BIT-1.
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_RELOAD = TW'(CLKS_PER_BIT - 1);

`ifdef PROF_TX_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif
  localparam int BIW = $clog2(NBYTES);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [31:0]     snap;
  logic [BIW-1:0]  byte_idx;
  logic [2:0]      bit_idx;
  logic [TW-1:0]   bit_timer;

  // Bytes of the dump in transmit order, all derived from the frozen snapshot.
  logic [7:0] frame_bytes [NBYTES];
  logic [7:0] cur_byte;

  always_comb begin
    frame_bytes[0] = snap[31:24];
    frame_bytes[1] = snap[23:16];
    frame_bytes[2] = snap[15:8];
    frame_bytes[3] = snap[7:0];
`ifdef PROF_TX_CHECKSUM_EN
    frame_bytes[4] = snap[31:24] ^ snap[23:16] ^ snap[15:8] ^ snap[7:0];
`endif
  end

  always_comb begin
    cur_byte = frame_bytes[byte_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      snap      <= 32'h0;
      byte_idx  <= '0;
      bit_idx   <= 3'd0;
      bit_timer <= '0;
      P_Tx      <= 1'b1;
      P_Busy    <= 1'b0;
      P_Done    <= 1'b0;
    end else begin
      P_Done <= 1'b0;

      case (state)
        IDLE: begin
          P_Tx <= 1'b1;
          // Accepting edge already drives the start bit, so the start bit
          // spans this edge plus CLKS_PER_BIT-1 timer decrements.
          if (P_Dump_Req && !P_Busy) begin
            snap      <= P_Count;
            byte_idx  <= '0;
            bit_idx   <= 3'd0;
            bit_timer <= BIT_RELOAD;
            P_Tx      <= 1'b0;
            P_Busy    <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          if (bit_timer != '0) begin
            bit_timer <= bit_timer - TW'(1);
          end else begin
            bit_timer <= BIT_RELOAD;
            bit_idx   <= 3'd0;
            P_Tx      <= cur_byte[0];
            state     <= DATA;
          end
        end

        DATA: begin
          if (bit_timer != '0) begin
            bit_timer <= bit_timer - TW'(1);
          end else begin
            bit_timer <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              P_Tx  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              P_Tx    <= cur_byte[bit_idx + 3'd1];
            end
          end
        end

        STOP: begin
          if (bit_timer != '0) begin
            bit_timer <= bit_timer - TW'(1);
          end else if (byte_idx == LAST_BYTE) begin
            // Busy drops here; the following IDLE cycle is the earliest
            // point a new request can be accepted.
            P_Tx   <= 1'b1;
            P_Busy <= 1'b0;
            P_Done <= 1'b1;
            state  <= IDLE;
          end else begin
            // Next frame starts immediately, no idle gap between frames.
            byte_idx  <= byte_idx + BIW'(1);
            bit_timer <= BIT_RELOAD;
            P_Tx      <= 1'b0;
            state     <= START;
          end
        end

        default: begin
          P_Tx   <= 1'b1;
          P_Busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prof_uart_tx.sv
module tb_prof_uart_tx;

  localparam int CPB = 4;
`ifdef PROF_TX_CHECKSUM_EN
  localparam int NF = 5;
`else
  localparam int NF = 4;
`endif
  localparam int FRAME = 10 * CPB;
  localparam int DUMP  = NF * FRAME;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] P_Count = 32'h0;
  logic        P_Dump_Req = 1'b0;
  logic        P_Tx;
  logic        P_Busy;
  logic        P_Done;

  int total = 0;
  int bad   = 0;

  // Per-cycle samples; index i is the value after edge k+i, k = accepting edge.
  logic tx_s   [0:511];
  logic busy_s [0:511];
  logic done_s [0:511];

  // 0x12345678 -> bytes, checksum 0x12^0x34^0x56^0x78 = 0x08
  logic [7:0] exp_a [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
  // 0xA5C30F81 -> bytes, checksum 0xA5^0xC3^0x0F^0x81 = 0xE8
  logic [7:0] exp_b [5] = '{8'hA5, 8'hC3, 8'h0F, 8'h81, 8'hE8};

  prof_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .P_Count    (P_Count),
    .P_Dump_Req (P_Dump_Req),
    .P_Tx       (P_Tx),
    .P_Busy     (P_Busy),
    .P_Done     (P_Done)
  );

  always #5 clk = ~clk;

  // Caller raises P_Dump_Req at a negedge; the next posedge is edge k.
  task automatic record(input int n, input int req_until, input int pulse_at, input bit change_count);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_s[i]   = P_Tx;
      busy_s[i] = P_Busy;
      done_s[i] = P_Done;
      P_Dump_Req = (i < req_until) || (i == pulse_at);
      if (change_count && i == 0) P_Count = 32'hFFFF_FFFF;
    end
  endtask

  // Decodes one frame starting at sample base, demanding every bit be held
  // exactly CPB cycles; returns {frame_ok, byte}.
  function automatic logic [8:0] decode(input int base);
    logic       ok;
    logic [7:0] b;
    logic       v;
    logic       want;
    ok = 1'b1;
    b  = 8'h00;
    for (int bi = 0; bi < 10; bi++) begin
      for (int j = 0; j < CPB; j++) begin
        v = tx_s[base + bi * CPB + j];
        if (bi == 0) want = 1'b0;
        else if (bi == 9) want = 1'b1;
        else begin
          if (j == 0) b[bi-1] = v;
          want = b[bi-1];
        end
        if (v !== 1'b0 && v !== 1'b1) ok = 1'b0;
        else if (v !== want) ok = 1'b0;
      end
    end
    return {ok, b};
  endfunction

  function automatic int count_hi_busy(input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i < hi; i++) if (busy_s[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_hi_done(input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i < hi; i++) if (done_s[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    P_Dump_Req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if ({P_Tx, P_Busy, P_Done} !== 3'b100) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: tx/busy/done=%b want 100", i, {P_Tx, P_Busy, P_Done});
      end
    end
  endtask

  task automatic test_basic_dump;
    logic [8:0] d;
    int c;
    @(negedge clk);
    P_Count = 32'h1234_5678;
    P_Dump_Req = 1'b1;
    record(DUMP + 20, 0, -1, 1'b0);

    total++;
    if ({tx_s[0], busy_s[0]} !== 2'b01) begin
      bad++;
      $display("FAIL basic_start_latency: tx/busy=%b want 01", {tx_s[0], busy_s[0]});
    end
    for (int f = 0; f < NF; f++) begin
      d = decode(f * FRAME);
      total++;
      if (d !== {1'b1, exp_a[f]}) begin
        bad++;
        $display("FAIL basic_byte%0d: ok/byte=%b/%h want 1/%h", f, d[8], d[7:0], exp_a[f]);
      end
    end
    c = count_hi_busy(0, DUMP + 20);
    total++;
    if (c != DUMP) begin
      bad++;
      $display("FAIL basic_busy_len: %0d cycles want %0d", c, DUMP);
    end
    total++;
    if ({busy_s[DUMP-1], busy_s[DUMP]} !== 2'b10) begin
      bad++;
      $display("FAIL basic_busy_fall: busy[%0d..%0d]=%b want 10", DUMP-1, DUMP, {busy_s[DUMP-1], busy_s[DUMP]});
    end
    c = count_hi_done(0, DUMP + 20);
    total++;
    if (done_s[DUMP] !== 1'b1 || c != 1) begin
      bad++;
      $display("FAIL basic_done: done@fall=%b pulses=%0d want 1/1", done_s[DUMP], c);
    end
    c = 0;
    for (int i = DUMP; i < DUMP + 20; i++) if (tx_s[i] !== 1'b1) c++;
    total++;
    if (c != 0) begin
      bad++;
      $display("FAIL basic_idle_tx: %0d non-high cycles want 0", c);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_snapshot_isolation;
    logic [8:0] d;
    @(negedge clk);
    P_Count = 32'h1234_5678;
    P_Dump_Req = 1'b1;
    record(DUMP + 10, 0, -1, 1'b1);
    for (int f = 0; f < NF; f++) begin
      d = decode(f * FRAME);
      total++;
      if (d !== {1'b1, exp_a[f]}) begin
        bad++;
        $display("FAIL snapshot_byte%0d: ok/byte=%b/%h want 1/%h", f, d[8], d[7:0], exp_a[f]);
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_busy_request;
    logic [8:0] d;
    int c;
    @(negedge clk);
    P_Count = 32'h1234_5678;
    P_Dump_Req = 1'b1;
    record(DUMP + 60, 0, 50, 1'b0);
    c = count_hi_busy(0, DUMP + 60);
    total++;
    if (c != DUMP) begin
      bad++;
      $display("FAIL busyreq_busy_len: %0d cycles want %0d", c, DUMP);
    end
    c = count_hi_done(0, DUMP + 60);
    total++;
    if (c != 1) begin
      bad++;
      $display("FAIL busyreq_done_count: %0d want 1", c);
    end
    d = decode(FRAME);
    total++;
    if (d !== {1'b1, exp_a[1]}) begin
      bad++;
      $display("FAIL busyreq_byte1: ok/byte=%b/%h want 1/%h", d[8], d[7:0], exp_a[1]);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_held_request;
    logic [8:0] d;
    int c;
    @(negedge clk);
    P_Count = 32'h1234_5678;
    P_Dump_Req = 1'b1;
    record(2 * DUMP + 21, DUMP + 40, -1, 1'b0);
    total++;
    if ({busy_s[DUMP], busy_s[DUMP+1], tx_s[DUMP+1]} !== 3'b010) begin
      bad++;
      $display("FAIL held_restart: busy@fall/busy+1/tx+1=%b want 010",
               {busy_s[DUMP], busy_s[DUMP+1], tx_s[DUMP+1]});
    end
    for (int f = 0; f < NF; f++) begin
      d = decode(DUMP + 1 + f * FRAME);
      total++;
      if (d !== {1'b1, exp_a[f]}) begin
        bad++;
        $display("FAIL held_second_byte%0d: ok/byte=%b/%h want 1/%h", f, d[8], d[7:0], exp_a[f]);
      end
    end
    c = count_hi_done(0, 2 * DUMP + 21);
    total++;
    if (done_s[2*DUMP+1] !== 1'b1 || c != 2) begin
      bad++;
      $display("FAIL held_done: done@2nd=%b pulses=%0d want 1/2", done_s[2*DUMP+1], c);
    end
    c = count_hi_busy(2 * DUMP + 1, 2 * DUMP + 21);
    total++;
    if (c != 0) begin
      bad++;
      $display("FAIL held_no_third: busy %0d cycles after release want 0", c);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_dump;
    logic [8:0] d;
    int c;
    @(negedge clk);
    P_Count = 32'h1234_5678;
    P_Dump_Req = 1'b1;
    // 56 samples after edge k lands inside byte 1 data bits (cycles 44..75).
    for (int i = 0; i < 56; i++) begin
      @(negedge clk);
      P_Dump_Req = 1'b0;
    end
    total++;
    if (P_Busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_busy_before: busy=%b want 1", P_Busy);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({P_Tx, P_Busy, P_Done} !== 3'b100) begin
      bad++;
      $display("FAIL midreset_outputs: tx/busy/done=%b want 100", {P_Tx, P_Busy, P_Done});
    end
    reset = 1'b0;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (P_Done !== 1'b0 || P_Busy !== 1'b0 || P_Tx !== 1'b1) c++;
    end
    total++;
    if (c != 0) begin
      bad++;
      $display("FAIL midreset_quiet: %0d non-idle cycles want 0", c);
    end

    @(negedge clk);
    P_Count = 32'hA5C3_0F81;
    P_Dump_Req = 1'b1;
    record(DUMP + 10, 0, -1, 1'b0);
    for (int f = 0; f < NF; f++) begin
      d = decode(f * FRAME);
      total++;
      if (d !== {1'b1, exp_b[f]}) begin
        bad++;
        $display("FAIL midreset_fresh_byte%0d: ok/byte=%b/%h want 1/%h", f, d[8], d[7:0], exp_b[f]);
      end
    end
    total++;
    if (done_s[DUMP] !== 1'b1 || busy_s[DUMP] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_fresh_done: done/busy=%b%b want 10", done_s[DUMP], busy_s[DUMP]);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic_dump;
    test_snapshot_isolation;
    test_busy_request;
    test_held_request;
    test_reset_mid_dump;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
